// File: rtl/dma_sg_launcher_pkg.sv
// Shared definitions for the scatter-gather DMA launcher: register map, control/status
// bit constants, error codes, FSM state encodings and the configuration step table.
package dma_sg_launcher_pkg;

    localparam logic [31:0] MM2S_DMACR    = 32'h0000_0000;
    localparam logic [31:0] MM2S_DMASR    = 32'h0000_0004;
    localparam logic [31:0] MM2S_CURDESC  = 32'h0000_0008;
    localparam logic [31:0] MM2S_TAILDESC = 32'h0000_0010;
    localparam logic [31:0] S2MM_DMACR    = 32'h0000_0030;
    localparam logic [31:0] S2MM_DMASR    = 32'h0000_0034;
    localparam logic [31:0] S2MM_CURDESC  = 32'h0000_0038;
    localparam logic [31:0] S2MM_TAILDESC = 32'h0000_0040;

    localparam logic [31:0] DMACR_RUN_IOC  = 32'h0000_1001;
    localparam logic [31:0] DMASR_IOC_MASK = 32'h0000_1000;
    localparam logic [31:0] DMASR_ERR_MASK = 32'h0000_0070;
    localparam logic [31:0] DMASR_IOC_W1C  = 32'h0000_1000;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_AXI     = 3'd1;
    localparam logic [2:0] ERR_DMASR   = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;

    localparam logic [3:0] STEP_LAST_CFG = 4'd5;
    localparam logic [3:0] STEP_CLR_MM2S = 4'd6;
    localparam logic [3:0] STEP_CLR_S2MM = 4'd7;

    typedef enum logic [3:0] {
        ST_IDLE, ST_WAIT_DESC, ST_WR_ADDR, ST_WR_RESP, ST_RD_ADDR,
        ST_RD_DATA, ST_CHECK, ST_CLEAR, ST_DONE, ST_ERROR
    } state_e;

    typedef enum logic [2:0] {
        AX_IDLE, AX_WRITE, AX_WRESP, AX_RADDR, AX_RDATA
    } axil_state_e;

    // Steps 0-5 program S2MM then MM2S; steps 6-7 acknowledge IOC on both channels.
    function automatic logic [31:0] step_addr(input logic [3:0] step);
        case (step)
            4'd0:    return S2MM_CURDESC;
            4'd1:    return S2MM_DMACR;
            4'd2:    return S2MM_TAILDESC;
            4'd3:    return MM2S_CURDESC;
            4'd4:    return MM2S_DMACR;
            4'd5:    return MM2S_TAILDESC;
            4'd6:    return MM2S_DMASR;
            default: return S2MM_DMASR;
        endcase
    endfunction

    function automatic logic [31:0] step_data(input logic [3:0] step, input logic [31:0] base);
        case (step)
            4'd0:    return base + 32'h0000_0100;
            4'd1:    return DMACR_RUN_IOC;
            4'd2:    return base + 32'h0000_0300;
            4'd3:    return base;
            4'd4:    return DMACR_RUN_IOC;
            4'd5:    return base + 32'h0000_0200;
            default: return DMASR_IOC_W1C;
        endcase
    endfunction

endpackage

// File: rtl/dma_sg_launcher_axil_single_master.sv
// One-outstanding AXI-Lite master: accepts a single read or write request while idle
// and returns a one-cycle ack carrying the response code and read data.
module axil_single_master
    import dma_sg_launcher_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic [1:0]  resp,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    axil_state_e state_q, state_d;
    logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  resp_q, resp_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d, ack_q, ack_d;

    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ack_d     = 1'b0;
        case (state_q)
            AX_IDLE: begin
                if (req) begin
                    if (we) begin
                        awaddr_d  = addr;
                        wdata_d   = wdata;
                        wstrb_d   = 4'hF;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = AX_WRITE;
                    end else begin
                        araddr_d  = addr;
                        arvalid_d = 1'b1;
                        state_d   = AX_RADDR;
                    end
                end
            end
            AX_WRITE: begin
                // Address and data channels retire independently; B is only awaited once both have.
                awvalid_d = awvalid_q & ~m_awready;
                wvalid_d  = wvalid_q & ~m_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = AX_WRESP;
                end
            end
            AX_WRESP: begin
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    ack_d    = 1'b1;
                    resp_d   = m_bresp;
                    state_d  = AX_IDLE;
                end
            end
            AX_RADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = AX_RDATA;
                end
            end
            AX_RDATA: begin
                if (m_rvalid) begin
                    rready_d = 1'b0;
                    ack_d    = 1'b1;
                    resp_d   = m_rresp;
                    rdata_d  = m_rdata;
                    state_d  = AX_IDLE;
                end
            end
            default: state_d = AX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= AX_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign resp      = resp_q;
    assign m_awaddr  = awaddr_q;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_araddr  = araddr_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule

// File: rtl/dma_sg_launcher.sv
// Programs both channels of a scatter-gather DMA for one ping-pong transfer, polls the
// status registers until both report IOC (or fail/time out) and acknowledges completion.
module dma_sg_launcher
    import dma_sg_launcher_pkg::*;
#(
    parameter logic [31:0] DESC_BASE  = 32'hA001_0000,
    parameter int unsigned POLL_LIMIT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        desc_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    state_e      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [31:0] poll_cnt_q, poll_cnt_d, status_q, status_d;
    logic [1:0]  cmpl_q, cmpl_d, cmpl_next;
    logic        poll_sel_q, poll_sel_d, done_q, done_d, err_q, err_d;
    logic [2:0]  err_code_q, err_code_d;

    logic        eng_req, eng_we, eng_ack;
    logic [31:0] eng_addr, eng_wdata, eng_rdata;
    logic [1:0]  eng_resp;

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        poll_cnt_d = poll_cnt_q;
        status_d   = status_q;
        cmpl_d     = cmpl_q;
        cmpl_next  = cmpl_q;
        poll_sel_d = poll_sel_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        eng_req    = 1'b0;
        eng_we     = 1'b0;
        eng_addr   = step_addr(step_q);
        eng_wdata  = step_data(step_q, DESC_BASE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    step_d     = 4'd0;
                    poll_cnt_d = '0;
                    cmpl_d     = '0;
                    poll_sel_d = 1'b0;
                    state_d    = ST_WAIT_DESC;
                end
            end
            ST_WAIT_DESC: if (desc_ready) state_d = ST_WR_ADDR;
            ST_WR_ADDR, ST_CLEAR: begin
                eng_req = 1'b1;
                eng_we  = 1'b1;
                state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (eng_ack) begin
                    if (eng_resp != 2'b00) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_AXI;
                        state_d    = ST_ERROR;
                    end else begin
                        step_d = step_q + 4'd1;
                        if (step_q == STEP_LAST_CFG) begin
                            state_d = ST_RD_ADDR;
                        end else if (step_q == STEP_CLR_MM2S) begin
                            state_d = ST_CLEAR;
                        end else if (step_q == STEP_CLR_S2MM) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_WR_ADDR;
                        end
                    end
                end
            end
            ST_RD_ADDR: begin
                eng_req    = 1'b1;
                eng_addr   = poll_sel_q ? S2MM_DMASR : MM2S_DMASR;
                poll_cnt_d = poll_cnt_q + 32'd1;
                state_d    = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (eng_ack) begin
                    if (eng_resp != 2'b00) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_AXI;
                        state_d    = ST_ERROR;
                    end else begin
                        status_d = eng_rdata;
                        state_d  = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                // A DMA error wins even when the same word also reports IOC.
                if ((status_q & DMASR_ERR_MASK) != 32'd0) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_DMASR;
                    state_d    = ST_ERROR;
                end else begin
                    cmpl_next[poll_sel_q] = cmpl_q[poll_sel_q] | ((status_q & DMASR_IOC_MASK) != 32'd0);
                    cmpl_d = cmpl_next;
                    if (&cmpl_next) begin
                        state_d = ST_CLEAR;
                    end else if (poll_cnt_q >= POLL_LIMIT) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                        state_d    = ST_ERROR;
                    end else begin
                        poll_sel_d = ~poll_sel_q;
                        state_d    = ST_RD_ADDR;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            poll_cnt_q <= '0;
            status_q   <= '0;
            cmpl_q     <= '0;
            poll_sel_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            poll_cnt_q <= poll_cnt_d;
            status_q   <= status_d;
            cmpl_q     <= cmpl_d;
            poll_sel_q <= poll_sel_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

    axil_single_master u_axil (
        .clk       (clk),
        .rst       (rst),
        .req       (eng_req),
        .we        (eng_we),
        .addr      (eng_addr),
        .wdata     (eng_wdata),
        .ack       (eng_ack),
        .rdata     (eng_rdata),
        .resp      (eng_resp),
        .m_awaddr  (awaddr),
        .m_awvalid (awvalid),
        .m_awready (awready),
        .m_wdata   (wdata),
        .m_wstrb   (wstrb),
        .m_wvalid  (wvalid),
        .m_wready  (wready),
        .m_bresp   (bresp),
        .m_bvalid  (bvalid),
        .m_bready  (bready),
        .m_araddr  (araddr),
        .m_arvalid (arvalid),
        .m_arready (arready),
        .m_rdata   (rdata),
        .m_rresp   (rresp),
        .m_rvalid  (rvalid),
        .m_rready  (rready)
    );

endmodule

// File: tb/tb_dma_sg_launcher.sv
// Directed bench for dma_sg_launcher with a behavioural AXI-Lite slave and DMASR model.
module tb_dma_sg_launcher;

    logic        clk, rst, start, desc_ready;
    logic        busy, done, err;
    logic [2:0]  err_code;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    int aw_delay = 0;
    int bad_wr   = -1;
    int rd_mode  = 0;
    int rbase    = 0;

    int wr_count = 0, rd_count = 0, aw_hs = 0;
    int aw_cnt = 0;
    logic aw_got = 0, w_got = 0, ar_got = 0;
    logic [31:0] ar_lat = '0;
    logic [31:0] wr_addr_log [64];
    logic [31:0] wr_data_log [64];
    logic [3:0]  wr_strb_log [64];
    logic [31:0] rd_addr_log [64];

    int done_cycles = 0, valid_cycles = 0, wv_only = 0, split_start = 0;
    logic awvalid_prev = 0, wvalid_prev = 0;

    logic [31:0] exp_addr [8];
    logic [31:0] exp_data [8];

    dma_sg_launcher #(.DESC_BASE(32'hA001_0000), .POLL_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .desc_ready(desc_ready),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dmasr_value(input int mode, input logic [31:0] addr, input int idx);
        if (mode == 0) return (idx >= 2) ? 32'h0000_1000 : 32'h0;
        if (mode == 1) return (addr == 32'h34) ? 32'h0000_1010 : 32'h0;
        return 32'h0;
    endfunction

    // Behavioural slave; handshake state clears on reset, transaction logs persist.
    always @(posedge clk) begin
        if (!rst) begin
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            arready <= 1'b0; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0; aw_cnt <= 0;
        end else begin
            awready <= 1'b0;
            wready  <= 1'b0;
            arready <= 1'b0;
            if (awvalid && !awready && !aw_got) begin
                if (aw_cnt >= aw_delay) awready <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end
            if (awvalid && awready) begin
                aw_got <= 1'b1;
                aw_cnt <= 0;
                aw_hs  <= aw_hs + 1;
                wr_addr_log[wr_count[5:0]] <= awaddr;
            end
            if (wvalid && !wready && !w_got) wready <= 1'b1;
            if (wvalid && wready) begin
                w_got <= 1'b1;
                wr_data_log[wr_count[5:0]] <= wdata;
                wr_strb_log[wr_count[5:0]] <= wstrb;
            end
            if (aw_got && w_got && !bvalid) begin
                bvalid <= 1'b1;
                bresp  <= (wr_count == bad_wr) ? 2'b10 : 2'b00;
            end
            if (bvalid && bready) begin
                bvalid   <= 1'b0;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
                wr_count <= wr_count + 1;
            end
            if (arvalid && !arready && !ar_got) arready <= 1'b1;
            if (arvalid && arready) begin
                ar_got <= 1'b1;
                ar_lat <= araddr;
                rd_addr_log[rd_count[5:0]] <= araddr;
            end
            if (ar_got && !rvalid) begin
                rvalid <= 1'b1;
                rresp  <= 2'b00;
                rdata  <= dmasr_value(rd_mode, ar_lat, rd_count - rbase);
            end
            if (rvalid && rready) begin
                rvalid   <= 1'b0;
                ar_got   <= 1'b0;
                rd_count <= rd_count + 1;
            end
        end
    end

    always @(negedge clk) begin
        done_cycles  <= done_cycles + int'(done);
        valid_cycles <= valid_cycles + int'(awvalid | wvalid | arvalid);
        wv_only      <= wv_only + int'(awvalid & ~wvalid);
        split_start  <= split_start + int'((awvalid & ~awvalid_prev & ~wvalid) | (wvalid & ~wvalid_prev & ~awvalid));
        awvalid_prev <= awvalid;
        wvalid_prev  <= wvalid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int maxc);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done || err) begin
                hit = 1'b1;
                break;
            end
        end
        check({tag, "_finished"}, 32'(hit), 32'd1);
    endtask

    task automatic check_writes(input string tag, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_awaddr%0d", tag, i), wr_addr_log[(base + i) % 64], exp_addr[i]);
            check($sformatf("%s_wdata%0d", tag, i), wr_data_log[(base + i) % 64], exp_data[i]);
            check($sformatf("%s_wstrb%0d", tag, i), 32'(wr_strb_log[(base + i) % 64]), 32'hF);
        end
    endtask

    initial begin
        int wbase, dbase, vbase, wvbase, spbase, awbase;
        bit seen;
        exp_addr = '{32'h38, 32'h30, 32'h40, 32'h08, 32'h00, 32'h10, 32'h04, 32'h34};
        exp_data = '{32'hA001_0100, 32'h0000_1001, 32'hA001_0300, 32'hA001_0000,
                     32'h0000_1001, 32'hA001_0200, 32'h0000_1000, 32'h0000_1000};
        rst = 1'b0; start = 1'b0; desc_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", {24'd0, busy, done, err, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_awaddr", awaddr, 32'd0);
        check("rst_wstrb", 32'(wstrb), 32'd0);
        rst = 1'b1;
        $display("step reset: checked idle outputs");

        // Nominal run
        desc_ready = 1'b1;
        wbase = wr_count; rbase = rd_count; dbase = done_cycles; wvbase = wv_only; spbase = split_start;
        pulse_start();
        wait_end("nominal", 2000);
        repeat (3) @(negedge clk);
        check("nominal_writes", 32'(wr_count - wbase), 32'd8);
        check_writes("nominal", wbase, 8);
        check("nominal_reads", 32'(rd_count - rbase), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("nominal_araddr%0d", i), rd_addr_log[(rbase + i) % 64], (i % 2 == 0) ? 32'h04 : 32'h34);
        check("nominal_done_width", 32'(done_cycles - dbase), 32'd1);
        check("nominal_busy_after", 32'(busy), 32'd0);
        check("nominal_err", {29'd0, err, err_code[1:0]}, 32'd0);
        check("nominal_aw_w_together", 32'(split_start - spbase), 32'd0);
        check("nominal_no_aw_only", 32'(wv_only - wvbase), 32'd0);
        $display("step nominal: %0d writes %0d reads", wr_count - wbase, rd_count - rbase);

        // Descriptor not ready
        desc_ready = 1'b0;
        wbase = wr_count; rbase = rd_count;
        pulse_start();
        vbase = valid_cycles;
        repeat (50) @(negedge clk);
        check("waitdesc_no_valid", 32'(valid_cycles - vbase), 32'd0);
        check("waitdesc_busy", 32'(busy), 32'd1);
        desc_ready = 1'b1;
        wait_end("waitdesc", 2000);
        repeat (3) @(negedge clk);
        check("waitdesc_writes", 32'(wr_count - wbase), 32'd8);
        check("waitdesc_first_addr", wr_addr_log[wbase % 64], 32'h38);
        $display("step wait_desc: sequence started after desc_ready");

        // awready delayed after wready
        aw_delay = 3;
        wbase = wr_count; rbase = rd_count; wvbase = wv_only; spbase = split_start; awbase = aw_hs;
        pulse_start();
        wait_end("awdelay", 3000);
        repeat (3) @(negedge clk);
        check("awdelay_aw_holds", 32'((wv_only - wvbase) > 0), 32'd1);
        check("awdelay_start_together", 32'(split_start - spbase), 32'd0);
        check("awdelay_b_count", 32'(wr_count - wbase), 32'd8);
        check("awdelay_aw_count", 32'(aw_hs - awbase), 32'd8);
        check_writes("awdelay", wbase, 8);
        aw_delay = 0;
        $display("step aw_delay: %0d writes", wr_count - wbase);

        // SLVERR on third write
        wbase = wr_count; rbase = rd_count;
        bad_wr = wbase + 2;
        pulse_start();
        wait_end("slverr", 2000);
        repeat (20) @(negedge clk);
        check("slverr_err", 32'(err), 32'd1);
        check("slverr_code", 32'(err_code), 32'd1);
        check("slverr_writes", 32'(wr_count - wbase), 32'd3);
        check("slverr_reads", 32'(rd_count - rbase), 32'd0);
        check("slverr_busy", 32'(busy), 32'd0);
        bad_wr = -1;
        $display("step slverr: err_code=%0d", err_code);

        // DMASR error bits with IOC set
        rd_mode = 1;
        wbase = wr_count; rbase = rd_count;
        pulse_start();
        wait_end("dmaerr", 2000);
        repeat (3) @(negedge clk);
        check("dmaerr_err", 32'(err), 32'd1);
        check("dmaerr_code", 32'(err_code), 32'd2);
        check("dmaerr_reads", 32'(rd_count - rbase), 32'd2);
        check("dmaerr_writes", 32'(wr_count - wbase), 32'd6);
        $display("step dmasr_error: err_code=%0d", err_code);

        // Poll timeout
        rd_mode = 2;
        wbase = wr_count; rbase = rd_count;
        pulse_start();
        wait_end("timeout", 3000);
        repeat (3) @(negedge clk);
        check("timeout_code", 32'(err_code), 32'd3);
        check("timeout_reads", 32'(rd_count - rbase), 32'd8);
        check("timeout_writes", 32'(wr_count - wbase), 32'd6);
        rd_mode = 0;
        $display("step timeout: %0d reads", rd_count - rbase);

        // Reset during a write
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (awvalid) begin
                seen = 1'b1;
                break;
            end
        end
        check("midrst_awvalid_seen", 32'(seen), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_ctrl", {24'd0, busy, done, err, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        check("midrst_err_code", 32'(err_code), 32'd0);
        check("midrst_awaddr", awaddr, 32'd0);
        check("midrst_wdata", wdata, 32'd0);
        check("midrst_araddr", araddr, 32'd0);
        check("midrst_wstrb", 32'(wstrb), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wbase = wr_count; rbase = rd_count; dbase = done_cycles;
        pulse_start();
        wait_end("postrst", 2000);
        repeat (3) @(negedge clk);
        check("postrst_writes", 32'(wr_count - wbase), 32'd8);
        check_writes("postrst", wbase, 8);
        check("postrst_done_width", 32'(done_cycles - dbase), 32'd1);
        $display("step mid_reset: clean rerun %0d writes", wr_count - wbase);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
